// File: rtl/tag_alloc_ctrl_pkg.sv
// Shared widths, tag lifecycle states and the modular sequence-number age compare
// used by the tag allocator.
package tag_alloc_ctrl_pkg;
  localparam int WIDTH_UOPS   = 4;
  localparam int WIDTH_COMMIT = 4;
  localparam int NUM_TAGS     = 64;
  localparam int NUM_ARCH     = 32;
  localparam int TAG_W        = 6;
  localparam int SQN_W        = 7;
  localparam int CNT_W        = 7;

  typedef enum logic [1:0] {
    TS_FREE      = 2'd0,
    TS_SPEC      = 2'd1,
    TS_COMMITTED = 2'd2
  } TagState;

  // True when a is strictly younger than b on the 128-entry sequence ring.
  function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return $signed(diff) > $signed(SQN_W'(0));
  endfunction
endpackage

// File: rtl/tag_alloc_ctrl_picker.sv
// Picks the WIDTH_UOPS lowest-index free tags, combinationally, by a cascade of
// priority encoders where each stage masks out the tag chosen by the stage before.
module tag_free_picker
  import tag_alloc_ctrl_pkg::*;
(
  input  logic [NUM_TAGS-1:0]                freeMask,
  output logic [WIDTH_UOPS-1:0][TAG_W-1:0]   pickTags,
  output logic [WIDTH_UOPS-1:0]              pickValid
);
  always_comb begin
    logic [NUM_TAGS-1:0] remaining;
    remaining = freeMask;
    pickTags  = '0;
    pickValid = '0;
    for (int l = 0; l < WIDTH_UOPS; l++) begin
      // Downward scan: the last hit written is the lowest set index.
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
        if (remaining[t]) begin
          pickTags[l]  = TAG_W'(t);
          pickValid[l] = 1'b1;
        end
      end
      if (pickValid[l]) remaining[pickTags[l]] = 1'b0;
    end
  end
endmodule

// File: rtl/tag_alloc_ctrl.sv
// Physical tag pool: offers the lowest free tags to rename, retires on commit, rolls back on mispredict.
// Offers are combinational from state; OUT_freeCount lags by one cycle. TAG_ALLOC_STATS_EN adds starve/rollback counters.
module tag_alloc_ctrl
  import tag_alloc_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              IN_mispr,
  input  logic [SQN_W-1:0]                  IN_misprSqN,
  input  logic [WIDTH_UOPS-1:0]             IN_issueValid,
  input  logic [WIDTH_UOPS*SQN_W-1:0]       IN_issueSqN,
  output logic [WIDTH_UOPS*TAG_W-1:0]       OUT_issueTags,
  output logic [WIDTH_UOPS-1:0]             OUT_issueTagsValid,
  input  logic [WIDTH_COMMIT-1:0]           IN_commitValid,
  input  logic [WIDTH_COMMIT-1:0]           IN_commitNewest,
  input  logic [WIDTH_COMMIT*(TAG_W+1)-1:0] IN_commitTagDst,
  input  logic [WIDTH_COMMIT*(TAG_W+1)-1:0] IN_commitPrevTag,
  output logic [CNT_W-1:0]                  OUT_freeCount
`ifdef TAG_ALLOC_STATS_EN
  ,
  output logic [31:0]                       OUT_starveCycles,
  output logic [31:0]                       OUT_rollbackTags
`endif
);
  TagState                  tagState  [NUM_TAGS];
  logic [SQN_W-1:0]         tagSqN    [NUM_TAGS];
  TagState                  nextState [NUM_TAGS];
  logic [SQN_W-1:0]         nextSqN   [NUM_TAGS];
  logic [NUM_TAGS-1:0]      freeMask;
  logic [NUM_TAGS-1:0]      rollbackMask;
  logic [WIDTH_UOPS-1:0][TAG_W-1:0] pickTags;
  logic [WIDTH_UOPS-1:0]    pickValid;
  logic [CNT_W-1:0]         nextFreeCount;

  always_comb begin
    freeMask     = '0;
    rollbackMask = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      freeMask[t]     = (tagState[t] == TS_FREE);
      rollbackMask[t] = IN_mispr && (tagState[t] == TS_SPEC) && sqn_younger(tagSqN[t], IN_misprSqN);
    end
  end

  tag_free_picker picker (
    .freeMask  (freeMask),
    .pickTags  (pickTags),
    .pickValid (pickValid)
  );

  assign OUT_issueTags      = pickTags;
  assign OUT_issueTagsValid = rst ? '0 : pickValid;

  always_comb begin
    logic [TAG_W:0] dst;
    logic [TAG_W:0] prev;
    dst       = '0;
    prev      = '0;
    nextState = tagState;
    nextSqN   = tagSqN;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (rollbackMask[t]) nextState[t] = TS_FREE;
    end
    if (!IN_mispr) begin
      for (int l = 0; l < WIDTH_UOPS; l++) begin
        if (IN_issueValid[l] && pickValid[l]) begin
          nextState[pickTags[l]] = TS_SPEC;
          nextSqN[pickTags[l]]   = IN_issueSqN[l*SQN_W +: SQN_W];
        end
      end
    end
    // Commits are applied last so they override a rollback of the same tag.
    for (int c = 0; c < WIDTH_COMMIT; c++) begin
      dst  = IN_commitTagDst[c*(TAG_W+1) +: TAG_W+1];
      prev = IN_commitPrevTag[c*(TAG_W+1) +: TAG_W+1];
      if (IN_commitValid[c]) begin
        if (!dst[TAG_W])
          nextState[dst[TAG_W-1:0]] = IN_commitNewest[c] ? TS_COMMITTED : TS_FREE;
        if (IN_commitNewest[c] && !prev[TAG_W])
          nextState[prev[TAG_W-1:0]] = TS_FREE;
      end
    end
  end

  always_comb begin
    nextFreeCount = '0;
    for (int t = 0; t < NUM_TAGS; t++) nextFreeCount += CNT_W'(nextState[t] == TS_FREE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tagState[t] <= (t < NUM_ARCH) ? TS_COMMITTED : TS_FREE;
        tagSqN[t]   <= '0;
      end
      OUT_freeCount <= CNT_W'(NUM_TAGS - NUM_ARCH);
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tagState[t] <= nextState[t];
        tagSqN[t]   <= nextSqN[t];
      end
      OUT_freeCount <= nextFreeCount;
    end
  end

`ifdef TAG_ALLOC_STATS_EN
  logic             starve;
  logic [CNT_W-1:0] rollbackCount;
  logic [32:0]      rollbackSum;

  assign starve = |(IN_issueValid & ~OUT_issueTagsValid);

  always_comb begin
    rollbackCount = '0;
    for (int t = 0; t < NUM_TAGS; t++) rollbackCount += CNT_W'(rollbackMask[t]);
  end

  assign rollbackSum = {1'b0, OUT_rollbackTags} + 33'(rollbackCount);

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_starveCycles <= '0;
      OUT_rollbackTags <= '0;
    end else begin
      if (starve && !(&OUT_starveCycles)) OUT_starveCycles <= OUT_starveCycles + 32'd1;
      OUT_rollbackTags <= rollbackSum[32] ? '1 : rollbackSum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Randomized and directed bench for tag_alloc_ctrl against a list-based pool model.
module tb_tag_alloc_ctrl;
  logic        clk = 1'b0;
  logic        rst, mispr;
  logic [6:0]  misprSqN;
  logic [3:0]  issueValid;
  logic [27:0] issueSqN;
  logic [23:0] issueTags;
  logic [3:0]  issueTagsValid;
  logic [3:0]  commitValid, commitNewest;
  logic [27:0] commitTagDst, commitPrevTag;
  logic [6:0]  freeCount;
`ifdef TAG_ALLOC_STATS_EN
  logic [31:0] starveCycles, rollbackTags;
`endif

  always #5 clk = ~clk;

  tag_alloc_ctrl dut (
    .clk(clk), .rst(rst), .IN_mispr(mispr), .IN_misprSqN(misprSqN),
    .IN_issueValid(issueValid), .IN_issueSqN(issueSqN),
    .OUT_issueTags(issueTags), .OUT_issueTagsValid(issueTagsValid),
    .IN_commitValid(commitValid), .IN_commitNewest(commitNewest),
    .IN_commitTagDst(commitTagDst), .IN_commitPrevTag(commitPrevTag),
    .OUT_freeCount(freeCount)
`ifdef TAG_ALLOC_STATS_EN
    , .OUT_starveCycles(starveCycles), .OUT_rollbackTags(rollbackTags)
`endif
  );

  int nTests = 0;
  int nFail  = 0;

  // Model: each tag is 'F'ree, 'S'peculative or 'C'ommitted, plus its sequence number.
  byte mState[64];
  int  mSqN[64];
  int  mStarve, mRollback;
  bit  used[64];

  function automatic int offerTag(int lane);
    int seen = 0;
    for (int t = 0; t < 64; t++)
      if (mState[t] == "F") begin
        if (seen == lane) return t;
        seen++;
      end
    return -1;
  endfunction

  function automatic int modelFree();
    int n = 0;
    for (int t = 0; t < 64; t++) if (mState[t] == "F") n++;
    return n;
  endfunction

  function automatic bit younger(int a, int b);
    int d = (a - b + 256) % 128;
    return d >= 1 && d <= 63;
  endfunction

  task automatic modelReset();
    for (int t = 0; t < 64; t++) begin
      mState[t] = (t < 32) ? "C" : "F";
      mSqN[t]   = 0;
    end
    mStarve = 0;
    mRollback = 0;
  endtask

  task automatic setIdle();
    mispr = 0; misprSqN = '0; issueValid = '0; issueSqN = '0;
    commitValid = '0; commitNewest = '0; commitTagDst = '0; commitPrevTag = '0;
  endtask

  task automatic setIssue(logic [3:0] v, int s0, int s1, int s2, int s3);
    issueValid = v;
    issueSqN = {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endtask

  // One clock: the model absorbs the inputs at the edge, outputs are then read at negedge.
  task automatic cycle();
    int  offers[4];
    byte ns[64];
    int  nq[64];
    int  dst, prev;
    bit  starved;
    @(posedge clk);
    if (rst) modelReset();
    else begin
      for (int l = 0; l < 4; l++) offers[l] = offerTag(l);
      ns = mState;
      nq = mSqN;
      starved = 0;
      for (int l = 0; l < 4; l++) if (issueValid[l] && offers[l] < 0) starved = 1;
      if (starved) mStarve++;
      if (mispr) begin
        for (int t = 0; t < 64; t++)
          if (mState[t] == "S" && younger(mSqN[t], int'(misprSqN))) begin
            ns[t] = "F";
            mRollback++;
          end
      end else begin
        for (int l = 0; l < 4; l++)
          if (issueValid[l] && offers[l] >= 0) begin
            ns[offers[l]] = "S";
            nq[offers[l]] = int'(issueSqN[l*7 +: 7]);
          end
      end
      for (int c = 0; c < 4; c++)
        if (commitValid[c]) begin
          dst  = int'(commitTagDst[c*7 +: 7]);
          prev = int'(commitPrevTag[c*7 +: 7]);
          if (dst < 64) ns[dst] = commitNewest[c] ? "C" : "F";
          if (commitNewest[c] && prev < 64) ns[prev] = "F";
        end
      mState = ns;
      mSqN = nq;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1;
    setIdle();
    cycle();
    rst = 0;
    #1;
  endtask

  task automatic pickTag(output logic [6:0] tg);
    int t;
    tg = 7'h40 | 7'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) return;
    for (int k = 0; k < 16; k++) begin
      t = $urandom_range(0, 63);
      if (!used[t]) begin
        used[t] = 1;
        tg = 7'(t);
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    setIdle();
    cycle();
    cycle();
    nTests++;
    if (issueTagsValid !== 4'b0) begin
      nFail++; $display("FAIL reset_valid: got %b want 0000", issueTagsValid);
    end
    rst = 0;
    #1;
    nTests++;
    if (freeCount !== 7'd32) begin
      nFail++; $display("FAIL reset_freeCount: got %0d want 32", freeCount);
    end
    for (int l = 0; l < 4; l++) begin
      nTests++;
      if (issueTagsValid[l] !== 1'b1 || issueTags[l*6 +: 6] !== 6'(32 + l)) begin
        nFail++;
        $display("FAIL reset_offer lane%0d: got v=%b tag=%0d want v=1 tag=%0d",
                 l, issueTagsValid[l], issueTags[l*6 +: 6], 32 + l);
      end
    end
  endtask

  task automatic test_exhaust();
    doReset();
    for (int c = 0; c < 8; c++) begin
      setIssue(4'hF, 5, 6, 7, 8);
      cycle();
      nTests++;
      if (freeCount !== 7'(modelFree())) begin
        nFail++; $display("FAIL exhaust_count c%0d: got %0d want %0d", c, freeCount, modelFree());
      end
    end
    setIdle();
    #1;
    nTests++;
    if (issueTagsValid !== 4'b0 || freeCount !== 7'd0) begin
      nFail++; $display("FAIL exhaust_empty: got v=%b cnt=%0d want v=0000 cnt=0", issueTagsValid, freeCount);
    end
  endtask

  task automatic test_partial();
    doReset();
    for (int c = 0; c < 7; c++) begin
      setIssue(4'hF, 20, 21, 22, 23);
      cycle();
    end
    setIssue(4'b0001, 24, 0, 0, 0);
    cycle();
    setIdle();
    #1;
    nTests++;
    if (issueTagsValid !== 4'b0111 || issueTags[5:0] !== 6'd61 || issueTags[17:12] !== 6'd63) begin
      nFail++; $display("FAIL partial_offer: got v=%b tags=%h want v=0111 lane0=61 lane2=63", issueTagsValid, issueTags);
    end
    setIssue(4'hF, 25, 26, 27, 28);
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd0 || issueTagsValid !== 4'b0) begin
      nFail++; $display("FAIL partial_drain: got cnt=%0d v=%b want cnt=0 v=0000", freeCount, issueTagsValid);
    end
  endtask

  task automatic test_mispredict_commit();
    doReset();
    setIssue(4'hF, 10, 11, 12, 13);
    cycle();
    setIdle();
    mispr = 1; misprSqN = 7'd11;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd30 || issueTags !== {6'd37, 6'd36, 6'd35, 6'd34}) begin
      nFail++; $display("FAIL mispr_rollback: got cnt=%0d tags=%h want cnt=30 tags=34..37", freeCount, issueTags);
    end
    commitValid = 4'b0001; commitNewest = 4'b0001; commitTagDst[6:0] = 7'd32; commitPrevTag[6:0] = 7'd3;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd31 || issueTags[5:0] !== 6'd3 || issueTags[11:6] !== 6'd34) begin
      nFail++; $display("FAIL commit_free: got cnt=%0d lane0=%0d lane1=%0d want 31/3/34", freeCount, issueTags[5:0], issueTags[11:6]);
    end
    // Tag 33 (SqN 11) is rolled back and committed in the same cycle: commit must win.
    mispr = 1; misprSqN = 7'd10;
    commitValid = 4'b0001; commitNewest = 4'b0001; commitTagDst[6:0] = 7'd33; commitPrevTag[6:0] = 7'h40;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd31 || issueTags[11:6] !== 6'd34) begin
      nFail++; $display("FAIL commit_beats_mispr: got cnt=%0d lane1=%0d want 31/34", freeCount, issueTags[11:6]);
    end
  endtask

  task automatic test_wraparound();
    doReset();
    setIssue(4'hF, 126, 127, 0, 1);
    cycle();
    setIdle();
    mispr = 1; misprSqN = 7'd127;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd30 || issueTags[5:0] !== 6'd34) begin
      nFail++; $display("FAIL wrap_mispr127: got cnt=%0d lane0=%0d want 30/34", freeCount, issueTags[5:0]);
    end
    mispr = 1; misprSqN = 7'd125;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (freeCount !== 7'd32 || issueTags[5:0] !== 6'd32) begin
      nFail++; $display("FAIL wrap_mispr125: got cnt=%0d lane0=%0d want 32/32", freeCount, issueTags[5:0]);
    end
  endtask

  task automatic test_random();
    int seq = 40;
    int o, e;
    logic [6:0] tg;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      setIdle();
      setIssue(4'($urandom_range(0, 15)), seq, seq + 1, seq + 2, seq + 3);
      seq = (seq + 4) % 128;
      if ($urandom_range(0, 9) == 0) begin
        mispr = 1;
        misprSqN = 7'((seq + 128 - $urandom_range(0, 24)) % 128);
      end
      for (int t = 0; t < 64; t++) used[t] = 0;
      for (int l = 0; l < 4; l++) begin
        o = offerTag(l);
        if (o >= 0) used[o] = 1;
      end
      commitValid  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      commitNewest = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      for (int c = 0; c < 4; c++) begin
        pickTag(tg); commitTagDst[c*7 +: 7] = tg;
        pickTag(tg); commitPrevTag[c*7 +: 7] = tg;
      end
      cycle();
      nTests++;
      if (freeCount !== 7'(modelFree())) begin
        nFail++; $display("FAIL rand_count c%0d: got %0d want %0d", cyc, freeCount, modelFree());
      end
      for (int l = 0; l < 4; l++) begin
        e = offerTag(l);
        nTests++;
        if (issueTagsValid[l] !== (e >= 0) || (e >= 0 && issueTags[l*6 +: 6] !== 6'(e))) begin
          nFail++;
          $display("FAIL rand_offer c%0d lane%0d: got v=%b tag=%0d want v=%b tag=%0d",
                   cyc, l, issueTagsValid[l], issueTags[l*6 +: 6], e >= 0, e);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    setIdle();
    setIssue(4'hF, 60, 61, 62, 63);
    cycle();
    doReset();
    nTests++;
    if (freeCount !== 7'd32 || issueTagsValid !== 4'hF || issueTags !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
      nFail++; $display("FAIL reset_midop: got cnt=%0d v=%b tags=%h want 32/1111/32..35", freeCount, issueTagsValid, issueTags);
    end
  endtask

`ifdef TAG_ALLOC_STATS_EN
  task automatic test_stats();
    doReset();
    nTests++;
    if (starveCycles !== 32'd0 || rollbackTags !== 32'd0) begin
      nFail++; $display("FAIL stats_reset: got starve=%0d rb=%0d want 0/0", starveCycles, rollbackTags);
    end
    for (int c = 0; c < 8; c++) begin
      setIssue(4'hF, 5, 6, 7, 8);
      cycle();
    end
    for (int c = 0; c < 5; c++) cycle();
    setIdle();
    #1;
    nTests++;
    if (starveCycles !== 32'd5 || starveCycles !== 32'(mStarve)) begin
      nFail++; $display("FAIL stats_starve: got %0d want 5 (model %0d)", starveCycles, mStarve);
    end
    mispr = 1; misprSqN = 7'd6;
    cycle();
    setIdle();
    #1;
    nTests++;
    if (rollbackTags !== 32'd16 || freeCount !== 7'd16) begin
      nFail++; $display("FAIL stats_rollback: got rb=%0d cnt=%0d want 16/16", rollbackTags, freeCount);
    end
  endtask
`endif

  initial begin
    rst = 1;
    setIdle();
    modelReset();
    test_reset();
    test_exhaust();
    test_partial();
    test_mispredict_commit();
    test_wraparound();
    test_random();
    test_reset_midop();
`ifdef TAG_ALLOC_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/tag_alloc_ctrl.md
Name: tag_alloc_ctrl

Overview:
- Owns the physical register tag pool (64 tags) that the rename stage draws from.
- Each cycle it offers up to WIDTH_UOPS free tags, one per rename lane.
- Tracks every tag as FREE, SPEC (speculative) or COMMITTED. Frees tags on commit and rolls back speculative allocations on branch mispredict, keyed by sequence number.
- Sits beside the rename table. It is the sole allocator/arbiter for the tag resource.

Parameters:
- WIDTH_UOPS, 4, rename/issue lanes per cycle.
- WIDTH_COMMIT, 4, commit lanes per cycle.
- NUM_TAGS, 64, physical tags; tag index width TAG_W = 6.
- NUM_ARCH, 32, architectural registers; tags 0..NUM_ARCH-1 hold the reset mapping.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- IN_mispr  in  1  branch mispredict this cycle.
- IN_misprSqN  in  7  SqN of the mispredicting branch.
- IN_issueValid  in  WIDTH_UOPS  lane i consumes OUT_issueTags[i].
- IN_issueSqN  in  WIDTH_UOPS*7  SqN of the allocating uop, per lane.
- OUT_issueTags  out  WIDTH_UOPS*6  offered tag per lane.
- OUT_issueTagsValid  out  WIDTH_UOPS  lane i's offer is valid.
- IN_commitValid  in  WIDTH_COMMIT  commit lane valid (rd != 0).
- IN_commitNewest  in  WIDTH_COMMIT  lane is the newest commit to its arch reg this cycle.
- IN_commitTagDst  in  WIDTH_COMMIT*7  committed tag; bit6 = 1 means non-physical.
- IN_commitPrevTag  in  WIDTH_COMMIT*7  previous committed tag of that arch reg.
- OUT_freeCount  out  7  number of FREE tags (0..64).

Behaviour:
- State is per tag: state[1:0] (FREE/SPEC/COMMITTED) and sqN[6:0].
- Reset:
  - Tags 0..NUM_ARCH-1 are COMMITTED; the rest are FREE.
  - All sqN are 0.
  - OUT_freeCount = 32 in the cycle after rst is sampled.
  - OUT_issueTagsValid = 0 while rst is high.
  - Reset mid-operation discards all SPEC state.
- Offer (combinational from current state):
  - Lane i gets the i-th lowest-index FREE tag.
  - OUT_issueTagsValid[i] = 1 iff at least i+1 tags are FREE.
  - Offers are independent of IN_issueValid.
  - Lanes with IN_issueValid = 0 leave their offered tag FREE; lane i never takes lane j's tag.
- Allocate (posedge):
  - For each i with IN_issueValid[i] && OUT_issueTagsValid[i] && !IN_mispr: state = SPEC, sqN = IN_issueSqN[i].
  - IN_issueValid without a valid offer is a requester error; it is ignored.
- Commit (posedge), per lane with IN_commitValid:
  - If IN_commitTagDst[6] == 0, that tag becomes COMMITTED.
  - If IN_commitNewest && IN_commitPrevTag[6] == 0, the prev tag becomes FREE.
  - A non-newest lane's dst tag becomes FREE instead, since an intra-group younger write supersedes it.
- Mispredict (posedge): every SPEC tag with $signed(sqN - IN_misprSqN) > 0 (7-bit wrap-around compare) becomes FREE. SPEC tags at or older than the branch stay SPEC.
- Simultaneous events:
  - Commit and mispredict in the same cycle: both apply. Commit wins on a given tag.
  - A tag freed in cycle N is offered from cycle N+1, never in the same cycle.
  - An allocation and a commit naming the same tag in one cycle is illegal.
- OUT_freeCount is registered: popcount of FREE after the update, so 1-cycle latency.
- Boundaries:
  - Pool empty: all valids are 0; rename stalls.
  - Exactly k < WIDTH_UOPS free: lanes 0..k-1 are valid.
  - Wrap-around: SqN compare is modular over 128. At most 64 uops are in flight.

Optional Feature:
- Macro TAG_ALLOC_STATS_EN.
- When defined:
  - Adds output OUT_starveCycles [31:0], counting cycles with any IN_issueValid[i] && !OUT_issueTagsValid[i].
  - Adds output OUT_rollbackTags [31:0], accumulating tags freed by mispredict.
  - Both reset to 0 and saturate at all-ones.
- When undefined, the ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package holds TAG_W = 6, SQN_W = 7, and the enum TagState {TS_FREE, TS_SPEC, TS_COMMITTED}.
- Package also holds the function sqn_younger(a, b), returning $signed(a - b) > 0.
- One natural sub-module, tag_free_picker: takes the 64-bit FREE mask and produces WIDTH_UOPS lowest-index tags plus valids by cascaded priority encode with mask-out.

Test Plan:
- Reset, then no activity:
  - OUT_freeCount = 32.
  - Offers are 32, 33, 34, 35, all valid.
- Allocate 4 lanes SqN 5..8 each cycle for 8 cycles:
  - Pool exhausts after cycle 8.
  - All valids 0; OUT_freeCount = 0.
- Allocate tags 32..35 with SqN 10..13, then IN_mispr with IN_misprSqN = 11:
  - Tags 34 and 35 return to FREE; 32 and 33 stay SPEC.
  - OUT_freeCount = 30 next cycle.
- Commit dst 32, prev 3, newest = 1:
  - Tag 32 becomes COMMITTED, tag 3 becomes FREE.
  - Next cycle tag 3 is offered on lane 0.
- Wrap-around: allocate SqN 126, 127, 0, 1, then mispredict with SqN 127 → only the SqN 0 and 1 tags are freed.
- TAG_ALLOC_STATS_EN defined: hold IN_issueValid = 4'hF with an empty pool for 5 cycles → OUT_starveCycles = 5.
